// File: rtl/dip_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : dip_scan_controller
// Function : Drives the load/shift strobes of the serial DIP-switch/button
//            chain, captures a 24-bit frame, debounces it over consecutive
//            identical scans, publishes switch data and button lines, and
//            keeps sticky write-one-to-clear button-press flags.
// Revision : 1.0 - initial release
// ============================================================================
module dip_scan_controller #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned STABLE_FRAMES  = 3,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scan_en,
    input  logic        i_DipData,
    input  logic [7:0]  i_btn_ack,
    output logic        o_DipLatch,
    output logic        o_DipClk,
    output logic [15:0] o_data,
    output logic [7:0]  o_buttons,
    output logic        o_update,
    output logic [7:0]  o_btn_pending,
    output logic        o_busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_FRAMES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [7:0]       BTN_RESET  = BTN_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [4:0]       LAST_BIT   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic             phase_q,   phase_d;     // 0 = shift clock low phase, 1 = high phase
    logic [4:0]       bit_q,     bit_d;
    logic [23:0]      frame_q,   frame_d;
    logic [23:0]      prev_q,    prev_d;      // previous raw frame
    logic [CNT_W-1:0] stable_q,  stable_d;
    logic [15:0]      data_q,    data_d;
    logic [7:0]       buttons_q, buttons_d;
    logic             update_q,  update_d;
    logic [7:0]       pending_q, pending_d;
    logic             latch_q,   latch_d;
    logic             dclk_q,    dclk_d;
    logic             busy_q,    busy_d;

    logic             div_last;
    logic [CNT_W-1:0] stable_inc;
    logic [7:0]       press_old;
    logic [7:0]       press_new;
    logic [7:0]       press_set;

    assign div_last   = (div_q == DIV_LAST);
    assign stable_inc = (stable_q >= STABLE_MAX) ? STABLE_MAX : (stable_q + CNT_ONE);
    assign press_old  = BTN_ACTIVE_LOW ? ~buttons_q     : buttons_q;
    assign press_new  = BTN_ACTIVE_LOW ? ~frame_q[7:0]  : frame_q[7:0];

    // State register plus all datapath registers; strobes are registered to stay glitch-free
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            phase_q   <= 1'b0;
            bit_q     <= 5'd0;
            frame_q   <= 24'd0;
            prev_q    <= 24'd0;
            stable_q  <= '0;
            data_q    <= 16'd0;
            buttons_q <= BTN_RESET;
            update_q  <= 1'b0;
            pending_q <= 8'd0;
            latch_q   <= 1'b1;
            dclk_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            data_q    <= data_d;
            buttons_q <= buttons_d;
            update_q  <= update_d;
            pending_q <= pending_d;
            latch_q   <= latch_d;
            dclk_q    <= dclk_d;
            busy_q    <= busy_d;
        end
    end

    // Scan sequencing, debounce decision and press-event capture
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        data_d    = data_q;
        buttons_d = buttons_q;
        update_d  = 1'b0;
        press_set = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (i_scan_en) begin
                    state_d = ST_LATCH;
                    div_d   = '0;
                end
            end

            ST_LATCH: begin
                if (div_last) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = 5'd0;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            ST_SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + DIV_ONE;
                end else begin
                    div_d = '0;
                    if (!phase_q) begin
                        // Sample just before the rising edge; MSB-first fill
                        frame_d = {frame_q[22:0], i_DipData};
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_CHECK;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end

            ST_CHECK: begin
                stable_d = (frame_q == prev_q) ? stable_inc : CNT_ONE;
                prev_d   = frame_q;
                if ((stable_d >= STABLE_MAX) && (frame_q != {data_q, buttons_q})) begin
                    data_d    = frame_q[23:8];
                    buttons_d = frame_q[7:0];
                    update_d  = 1'b1;
                    press_set = press_new & ~press_old;
                end
                div_d   = '0;
                state_d = i_scan_en ? ST_LATCH : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new press outranks a simultaneous acknowledge
        pending_d = (pending_q & ~i_btn_ack) | press_set;
        latch_d   = (state_d != ST_LATCH);
        dclk_d    = (state_d == ST_SHIFT) && phase_d;
        busy_d    = (state_d != ST_IDLE);
    end

    assign o_DipLatch    = latch_q;
    assign o_DipClk      = dclk_q;
    assign o_data        = data_q;
    assign o_buttons     = buttons_q;
    assign o_update      = update_q;
    assign o_btn_pending = pending_q;
    assign o_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dip_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dip_scan_controller
// Function : Directed self-checking bench for dip_scan_controller, with a
//            behavioural shift-chain model per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dip_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    // Default-parameter instance
    logic        scan_en = 1'b0;
    logic        dip_data;
    logic [7:0]  btn_ack = 8'd0;
    logic        latch, dclk, update, busy;
    logic [15:0] data;
    logic [7:0]  buttons, pending;

    // CLK_DIV=1, STABLE_FRAMES=1 instance
    logic        f_scan_en = 1'b0;
    logic        f_dip_data;
    logic [7:0]  f_btn_ack = 8'd0;
    logic        f_latch, f_dclk, f_update, f_busy;
    logic [15:0] f_data;
    logic [7:0]  f_buttons, f_pending;

    int n_cmp = 0;
    int n_err = 0;
    int upd_total = 0;

    always #5 clk = ~clk;

    dip_scan_controller u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .i_DipData(dip_data),
        .i_btn_ack(btn_ack), .o_DipLatch(latch), .o_DipClk(dclk), .o_data(data),
        .o_buttons(buttons), .o_update(update), .o_btn_pending(pending), .o_busy(busy)
    );

    dip_scan_controller #(.CLK_DIV(1), .STABLE_FRAMES(1), .BTN_ACTIVE_LOW(1'b1)) u_dut_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(f_scan_en), .i_DipData(f_dip_data),
        .i_btn_ack(f_btn_ack), .o_DipLatch(f_latch), .o_DipClk(f_dclk), .o_data(f_data),
        .o_buttons(f_buttons), .o_update(f_update), .o_btn_pending(f_pending), .o_busy(f_busy)
    );

    // Chain models: parallel load while latch is low, shift on rising shift clock
    logic [23:0] pat = 24'd0, sr = 24'd0;
    logic        dclk_prev = 1'b0;
    always @(posedge clk) begin
        dclk_prev <= dclk;
        if (!latch) sr <= pat;
        else if (dclk && !dclk_prev) sr <= {sr[22:0], 1'b0};
    end
    assign dip_data = sr[23];

    logic [23:0] f_pat = 24'd0, f_sr = 24'd0;
    logic        f_dclk_prev = 1'b0;
    always @(posedge clk) begin
        f_dclk_prev <= f_dclk;
        if (!f_latch) f_sr <= f_pat;
        else if (f_dclk && !f_dclk_prev) f_sr <= {f_sr[22:0], 1'b0};
    end
    assign f_dip_data = f_sr[23];

    // Count update pulses of the default instance
    always @(negedge clk) if (update) upd_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the first negedge at which the chain load goes low
    task automatic wait_latch_fall(input string tag);
        logic prev;
        bit   seen;
        prev = latch;
        seen = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (prev && !latch) seen = 1'b1;
            prev = latch;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // From the current negedge, count cycles until o_update appears
    task automatic run_to_update(output int n, output int lat_low, output int pulses, output bit found);
        logic prev_clk;
        prev_clk = dclk;
        lat_low  = 0;
        pulses   = 0;
        found    = 1'b0;
        n        = 0;
        for (int k = 1; k <= 700 && !found; k++) begin
            @(negedge clk);
            if (update) begin
                found = 1'b1;
                n     = k;
            end else begin
                if (!latch) lat_low++;
                if (dclk && !prev_clk) pulses++;
            end
            prev_clk = dclk;
        end
    endtask

    initial begin
        int  n, lat_low, pulses, u0;
        bit  found;

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_latch",   {31'd0, latch},   32'd1);
        check("rst_dclk",    {31'd0, dclk},    32'd0);
        check("rst_data",    {16'd0, data},    32'h0);
        check("rst_buttons", {24'd0, buttons}, 32'hFF);
        check("rst_pending", {24'd0, pending}, 32'h0);
        check("rst_update",  {31'd0, update},  32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- first debounced frame ----------------
        pat = 24'hA5C37F;
        scan_en = 1'b1;
        run_to_update(n, lat_low, pulses, found);
        check("first_upd_found", {31'd0, found}, 32'd1);
        check("first_upd_cycle", n, 32'd592);
        check("latch_low_3frames", lat_low, 32'd12);
        check("dclk_pulses_3frames", pulses, 32'd72);
        check("f1_data",    {16'd0, data},    32'hA5C3);
        check("f1_buttons", {24'd0, buttons}, 32'h7F);
        check("f1_pending", {24'd0, pending}, 32'h80);
        @(negedge clk);
        check("update_one_cycle", {31'd0, update}, 32'd0);

        // ---------------- single-frame glitch on bit 0 ----------------
        wait_latch_fall("wl_glitch_a");
        pat = 24'hA5C37E;
        u0 = upd_total;
        wait_latch_fall("wl_glitch_b");
        pat = 24'hA5C37F;
        repeat (3) wait_latch_fall("wl_glitch_c");
        check("glitch_no_update", upd_total - u0, 32'd0);
        check("glitch_buttons", {24'd0, buttons}, 32'h7F);

        // ---------------- bit 0 low for three frames ----------------
        wait_latch_fall("wl_b0_a");
        pat = 24'hA5C37E;
        u0 = upd_total;
        wait_latch_fall("wl_b0_b");
        wait_latch_fall("wl_b0_c");
        check("b0_two_frames_no_upd", upd_total - u0, 32'd0);
        wait_latch_fall("wl_b0_d");
        check("b0_update_pulse", {31'd0, update}, 32'd1);
        @(negedge clk);
        check("b0_update_count", upd_total - u0, 32'd1);
        check("b0_data",    {16'd0, data},    32'hA5C3);
        check("b0_buttons", {24'd0, buttons}, 32'h7E);
        check("b0_pending", {24'd0, pending}, 32'h81);

        // ---------------- write-one-to-clear ----------------
        btn_ack = 8'h01;
        @(negedge clk);
        btn_ack = 8'h00;
        check("ack_bit0", {24'd0, pending}, 32'h80);

        // Release bit 7: not flagged
        wait_latch_fall("wl_rel_a");
        pat = 24'hA5C3FE;
        repeat (3) wait_latch_fall("wl_rel_b");
        @(negedge clk);
        check("rel_buttons", {24'd0, buttons}, 32'hFE);
        check("rel_pending", {24'd0, pending}, 32'h80);
        btn_ack = 8'h80;
        @(negedge clk);
        btn_ack = 8'h00;
        check("ack_bit7", {24'd0, pending}, 32'h00);

        // Press bit 7 with an acknowledge in the very CHECK cycle
        wait_latch_fall("wl_set_a");
        pat = 24'hA5C37E;
        wait_latch_fall("wl_set_b");
        wait_latch_fall("wl_set_c");
        repeat (196) @(negedge clk);
        btn_ack = 8'h80;
        @(negedge clk);
        btn_ack = 8'h00;
        check("setwins_update",  {31'd0, update},  32'd1);
        check("setwins_pending", {24'd0, pending}, 32'h80);
        @(negedge clk);
        check("setwins_hold", {24'd0, pending}, 32'h80);

        // ---------------- stop mid-frame ----------------
        wait_latch_fall("wl_stop");
        repeat (50) @(negedge clk);
        scan_en = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 400 && !found; k++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                n = k;
            end
        end
        check("stop_cycles_to_idle", n, 32'd147);
        check("stop_latch", {31'd0, latch}, 32'd1);
        check("stop_dclk",  {31'd0, dclk},  32'd0);
        repeat (10) @(negedge clk);
        check("stop_stays_idle", {31'd0, busy}, 32'd0);
        scan_en = 1'b1;
        @(negedge clk);
        check("restart_latch", {31'd0, latch}, 32'd0);
        check("restart_busy",  {31'd0, busy},  32'd1);

        // ---------------- reset during SHIFT bit 10 ----------------
        repeat (86) @(negedge clk);
        check("mid_shift_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_latch",   {31'd0, latch},   32'd1);
        check("arst_dclk",    {31'd0, dclk},    32'd0);
        check("arst_busy",    {31'd0, busy},    32'd0);
        check("arst_data",    {16'd0, data},    32'h0);
        check("arst_buttons", {24'd0, buttons}, 32'hFF);
        check("arst_pending", {24'd0, pending}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_to_update(n, lat_low, pulses, found);
        check("post_rst_found", {31'd0, found}, 32'd1);
        check("post_rst_cycle", n, 32'd592);
        check("post_rst_buttons", {24'd0, buttons}, 32'h7E);
        check("post_rst_pending", {24'd0, pending}, 32'h81);

        // ---------------- CLK_DIV=1, STABLE_FRAMES=1 ----------------
        f_pat = 24'h123456;
        f_scan_en = 1'b1;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 200 && !found; k++) begin
            @(negedge clk);
            if (f_update) begin
                found = 1'b1;
                n = k;
            end
        end
        check("fast_first_cycle", n, 32'd51);
        check("fast_f1_data",    {16'd0, f_data},    32'h1234);
        check("fast_f1_buttons", {24'd0, f_buttons}, 32'h56);
        check("fast_f1_pending", {24'd0, f_pending}, 32'hA9);
        check("fast_f2_latch",   {31'd0, f_latch},   32'd0);
        f_pat = 24'hABCDEF;
        repeat (49) @(negedge clk);
        check("fast_f2_pre_update", {31'd0, f_update}, 32'd0);
        @(negedge clk);
        check("fast_f2_update",  {31'd0, f_update},  32'd1);
        check("fast_f2_data",    {16'd0, f_data},    32'hABCD);
        check("fast_f2_buttons", {24'd0, f_buttons}, 32'hEF);
        check("fast_f2_pending", {24'd0, f_pending}, 32'hB9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dip_scan_controller.md
# dip_scan_controller

Sequencer and conditioner for the serial DIP-switch/button shift chain on the 8-bit processor board. Generates the chain's active-low load pulse and a divided shift clock, and shifts in a 24-bit frame. Debounces the frame over consecutive identical scans and publishes stable switch data plus eight button lines. Turns button presses into sticky pending flags that the processor clears with a write-one-to-clear acknowledge.

## Interface
Parameters:
- CLK_DIV, 4, i_clk cycles per shift-clock phase (≥1)
- STABLE_FRAMES, 3, consecutive identical frames required before outputs update (≥1)
- BTN_ACTIVE_LOW, 1, 1: button bit 0 = pressed

Ports:
- i_clk  in  1  system clock, all logic on posedge
- i_rst_n  in  1  asynchronous, active-low reset
- i_scan_en  in  1  1 = scan continuously; 0 = stop after current frame
- i_DipData  in  1  serial data from chain
- i_btn_ack  in  8  W1C clear of o_btn_pending bits
- o_DipLatch  out  1  chain load, active low
- o_DipClk  out  1  chain shift clock
- o_data  out  16  debounced switch data = frame[23:8]
- o_buttons  out  8  debounced button lines = frame[7:0]
- o_update  out  1  one-cycle pulse when o_data/o_buttons change
- o_btn_pending  out  8  sticky press events
- o_busy  out  1  1 while not IDLE

## Operation
- States: IDLE, LATCH, SHIFT, CHECK.
- IDLE: o_DipLatch=1, o_DipClk=0. i_scan_en=1 → LATCH next cycle.
- LATCH: o_DipLatch=0, o_DipClk=0 for CLK_DIV cycles → SHIFT, bit index 0.
- SHIFT: 24 bit periods, each CLK_DIV cycles o_DipClk=0 then CLK_DIV cycles o_DipClk=1. i_DipData sampled on the last low-phase cycle. First sampled bit → frame[23], last → frame[0]. After bit 23's high phase → CHECK.
- CHECK (1 cycle): if frame == previous raw frame, stable_cnt = min(stable_cnt+1, STABLE_FRAMES), else stable_cnt = 1. Previous raw frame ← frame. If stable_cnt becomes ≥ STABLE_FRAMES and frame ≠ {o_data,o_buttons}, load outputs and pulse o_update. Next: LATCH if i_scan_en, else IDLE.
- i_scan_en is sampled only in IDLE and CHECK. Deassertion mid-frame never truncates a frame.
- Press detect: pressed[b] = BTN_ACTIVE_LOW ? ~o_buttons[b] : o_buttons[b]. A 0→1 transition of pressed[b] on an output update sets o_btn_pending[b].
- i_btn_ack[b]=1 clears o_btn_pending[b]. If set and clear occur in the same cycle, set wins.
- Release events are not flagged.

## Timing
- Reset (async assert, sync effect on next edge after release):
  - state IDLE, o_DipLatch=1, o_DipClk=0, o_data=0.
  - o_buttons = all-ones if BTN_ACTIVE_LOW else 0 (released).
  - o_btn_pending=0, o_update=0, o_busy=0, stable_cnt=0, previous raw frame = 0.
- Reset mid-frame: partial frame discarded, no o_update.
- Frame period with continuous i_scan_en: CLK_DIV + 48·CLK_DIV + 1 cycles (197 for CLK_DIV=4).
- Output update happens on the CHECK edge. o_update is high the cycle the new values first appear.
- Minimum latency from a stable chain change to o_update: STABLE_FRAMES full frames (the first frame after reset also counts only as 1).
- o_busy = 1 in LATCH, SHIFT, CHECK.
- Identical stable frames repeating: no further o_update; stable_cnt saturates.

## Test plan
- Reset then i_scan_en=1, chain model holding 0xA5C3_7F (bits 23..0), CLK_DIV=4 → o_DipLatch low 4 cycles, 24 o_DipClk pulses. o_update only at end of frame 3 (cycle ≈ 591). o_data=0xA5C3, o_buttons=0x7F, o_btn_pending=0x80.
- Same frame, then bit 0 glitches low for one frame only → no o_update, outputs unchanged. Bit 0 low for 3 consecutive frames → o_update; o_btn_pending[0]=1.
- o_btn_pending=0x81, drive i_btn_ack=0x01 one cycle → pending 0x80. Ack coinciding with a new press on bit 7 → bit 7 stays 1.
- Drop i_scan_en mid-SHIFT → frame completes, CHECK runs, then IDLE with o_busy=0 and o_DipLatch=1. Re-enable → LATCH on next cycle.
- Assert i_rst_n=0 during SHIFT bit 10 → outputs immediately at reset values. After release, 3 full frames are required before the first o_update.
- CLK_DIV=1, STABLE_FRAMES=1 → frame period 50 cycles. Each changed frame produces o_update in the same frame's CHECK.
